// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolution signals of the branch predictor.
// Valid/ready semantics: lookup has no handshake; an update is accepted on every clock edge where u_valid=1.
interface branch_predictor_if;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        u_valid;
  logic [3:0]  u_bj_inst;
  logic [31:0] u_pc;
  logic        u_taken;
  logic [31:0] u_target;
  logic        u_pred_taken;
  logic [31:0] u_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output f_pc, u_valid, u_bj_inst, u_pc, u_taken, u_target, u_pred_taken, u_pred_target,
    input  f_pred_taken, f_pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  f_pc, u_valid, u_bj_inst, u_pc, u_taken, u_target, u_pred_taken, u_pred_target,
    output f_pred_taken, f_pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: same-cycle fetch prediction,
// training from execute-stage resolution, and saturating performance counters.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);
  localparam int TAG_W = 32 - IDX_BITS - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
    logic             jmp;
  } entry_t;

  localparam entry_t RESET_ENT = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01, jmp: 1'b0};

  entry_t bt_q [ENTRIES];
  entry_t entry_d;
  entry_t f_ent;
  entry_t u_ent;

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] u_idx;
  logic                f_hit;
  logic                u_hit;
  logic                ctl;
  logic                is_jmp;
  logic                wr_en;
  logic                mis;
  logic [31:0]         stat_br_q, stat_br_d;
  logic [31:0]         stat_mis_q, stat_mis_d;

  // Fetch lookup reads the table as it stood before this cycle's update.
  always_comb begin
    f_idx = bp.f_pc[IDX_BITS+1:2];
    f_ent = bt_q[f_idx];
    f_hit = f_ent.valid && (f_ent.tag == bp.f_pc[31:IDX_BITS+2]);
  end

  assign bp.f_pred_taken  = f_hit && (f_ent.jmp || f_ent.ctr[1]);
  assign bp.f_pred_target = bp.f_pred_taken ? f_ent.target : bp.f_pc + 32'd4;

  assign ctl    = bp.u_valid && bp.u_bj_inst[3] && (bp.u_bj_inst != 4'b1010);
  assign is_jmp = (bp.u_bj_inst == 4'b1011);
  assign mis    = ctl && ((bp.u_taken != bp.u_pred_taken) ||
                          (bp.u_taken && (bp.u_pred_target != bp.u_target)));

  assign bp.mispredict  = mis;
  assign bp.redirect_pc = bp.u_taken ? bp.u_target : bp.u_pc + 32'd4;

  always_comb begin
    u_idx   = bp.u_pc[IDX_BITS+1:2];
    u_ent   = bt_q[u_idx];
    u_hit   = u_ent.valid && (u_ent.tag == bp.u_pc[31:IDX_BITS+2]);
    wr_en   = 1'b0;
    entry_d = u_ent;
    if (ctl) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (is_jmp) begin
          entry_d.jmp    = 1'b1;
          entry_d.ctr    = 2'b11;
          entry_d.target = bp.u_target;
        end else if (bp.u_taken) begin
          if (u_ent.ctr != 2'b11) entry_d.ctr = u_ent.ctr + 2'd1;
          entry_d.target = bp.u_target;
        end else begin
          if (u_ent.ctr != 2'b00) entry_d.ctr = u_ent.ctr - 2'd1;
        end
      end else if (bp.u_taken) begin
        // Taken miss evicts whatever aliases at this index.
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = bp.u_pc[31:IDX_BITS+2];
        entry_d.target = bp.u_target;
        entry_d.ctr    = is_jmp ? 2'b11 : 2'b10;
        entry_d.jmp    = is_jmp;
      end
    end
  end

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (ctl && (stat_br_q != 32'hFFFF_FFFF))  stat_br_d  = stat_br_q + 32'd1;
    if (mis && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bt_q[i] <= RESET_ENT;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (wr_en) bt_q[u_idx] <= entry_d;
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor: a behavioural BTB model feeds an expected
// queue that a negedge monitor drains against the DUT outputs.
module tb_branch_predictor;
  localparam int ENTRIES = 64;
  localparam int IB      = 6;
  localparam int W       = 130;

  logic clk;
  logic rst_n;
  branch_predictor_if bp_bus ();

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_jmp   [ENTRIES];
  longint      m_sb, m_sm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1; m_jmp[i] = 0;
    end
    m_sb = 0; m_sm = 0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (ENTRIES * 4);
  endfunction

  task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    t   = hit && (m_jmp[i] || m_ctr[i] >= 2);
    tg  = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic drive(input logic [31:0] fpc, input logic uv, input logic [3:0] cls,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
    logic        pt, ctl, jump, mis;
    logic [31:0] ptg, rd;
    int          i;
    bit          hit;
    @(posedge clk); #1;
    bp_bus.f_pc = fpc; bp_bus.u_valid = uv; bp_bus.u_bj_inst = cls; bp_bus.u_pc = upc;
    bp_bus.u_taken = ut; bp_bus.u_target = utgt;
    bp_bus.u_pred_taken = upt; bp_bus.u_pred_target = uptgt;
    model_predict(fpc, pt, ptg);
    ctl  = uv && (cls inside {4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15});
    jump = (cls == 4'd11);
    mis  = ctl && ((ut != upt) || (ut && uptgt != utgt));
    rd   = ut ? utgt : upc + 32'd4;
    exp_q.push_back({pt, ptg, mis, rd, 32'(m_sb), 32'(m_sm)});
    if (ctl) begin
      i   = idx_of(upc);
      hit = m_valid[i] && (m_tag[i] == tag_of(upc));
      if (hit) begin
        if (jump) begin
          m_jmp[i] = 1; m_ctr[i] = 3; m_tgt[i] = utgt;
        end else if (ut) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt;
        m_ctr[i] = jump ? 3 : 2; m_jmp[i] = jump;
      end
      if (m_sb < 64'hFFFF_FFFF) m_sb++;
    end
    if (mis && m_sm < 64'hFFFF_FFFF) m_sm++;
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(fpc, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Monitor: every driven cycle produces one set of outputs sampled at negedge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("f_pred_taken",     {31'b0, bp_bus.f_pred_taken}, {31'b0, e[129]});
      chk("f_pred_target",    bp_bus.f_pred_target,     e[128:97]);
      chk("mispredict",       {31'b0, bp_bus.mispredict},   {31'b0, e[96]});
      chk("redirect_pc",      bp_bus.redirect_pc,       e[95:64]);
      chk("stat_branches",    bp_bus.stat_branches,     e[63:32]);
      chk("stat_mispredicts", bp_bus.stat_mispredicts,  e[31:0]);
    end
  end

  initial begin
    #2_000_000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] fpc, upc, utgt, uptgt;
    logic [3:0]  cls;
    logic        uv, ut, upt;
    logic [3:0]  cls_tab [10];
    cls_tab = '{4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd10, 4'd3};

    rst_n = 1'b0;
    bp_bus.f_pc = 32'h100; bp_bus.u_valid = 0; bp_bus.u_bj_inst = 0; bp_bus.u_pc = 0;
    bp_bus.u_taken = 0; bp_bus.u_target = 0; bp_bus.u_pred_taken = 0; bp_bus.u_pred_target = 0;
    model_reset();
    #3;
    chk("reset_pred_taken",  {31'b0, bp_bus.f_pred_taken}, 32'd0);
    chk("reset_pred_target", bp_bus.f_pred_target, 32'h104);
    chk("reset_stat_br",     bp_bus.stat_branches, 32'd0);
    chk("reset_stat_mis",    bp_bus.stat_mispredicts, 32'd0);
    #19 rst_n = 1'b1;

    // BEQ taken miss: allocate with ctr=10
    drive(32'h100, 1, 4'd8, 32'h100, 1, 32'h80, 0, 32'h104);
    settle();
    chk("beq_mispredict", {31'b0, bp_bus.mispredict}, 32'd1);
    chk("beq_redirect",   bp_bus.redirect_pc, 32'h80);
    idle(32'h100);
    settle();
    chk("beq_trained_taken",  {31'b0, bp_bus.f_pred_taken}, 32'd1);
    chk("beq_trained_target", bp_bus.f_pred_target, 32'h80);

    // Counter walk: 10 -> 01 -> 00 -> 00, then up 01,10,11,11
    for (int k = 0; k < 3; k++) drive(32'h100, 1, 4'd8, 32'h100, 0, 32'h80, 0, 32'h104);
    idle(32'h100);
    settle();
    chk("ctr_floor_not_taken", {31'b0, bp_bus.f_pred_taken}, 32'd0);
    for (int k = 0; k < 4; k++) drive(32'h100, 1, 4'd8, 32'h100, 1, 32'h80, 1, 32'h80);
    idle(32'h100);

    // JAL allocation aliases index 0 and evicts the 0x100 branch
    drive(32'h100, 1, 4'd11, 32'h200, 1, 32'h400, 0, 32'h204);
    idle(32'h200);
    settle();
    chk("jal_pred_target", bp_bus.f_pred_target, 32'h400);
    idle(32'h100);
    settle();
    chk("alias_miss_target", bp_bus.f_pred_target, 32'h104);
    drive(32'h200, 1, 4'd11, 32'h200, 1, 32'h400, 1, 32'h400);
    settle();
    chk("jal_no_mispredict", {31'b0, bp_bus.mispredict}, 32'd0);

    // Same-cycle lookup/update on index 0: lookup shows the old JAL entry
    drive(32'h200, 1, 4'd8, 32'h300, 1, 32'h500, 0, 32'h304);
    settle();
    chk("no_bypass_target", bp_bus.f_pred_target, 32'h400);
    idle(32'h300);
    idle(32'h200);

    // Non-branch classes must be ignored
    drive(32'h300, 1, 4'd0,  32'h300, 0, 32'h0, 1, 32'h500);
    drive(32'h300, 1, 4'd10, 32'h300, 0, 32'h0, 1, 32'h500);
    drive(32'h300, 1, 4'd7,  32'h300, 1, 32'h40, 0, 32'h304);
    idle(32'h300);

    // Random traffic over a small PC space so hits, aliases and saturation all occur
    for (int n = 0; n < 2000; n++) begin
      fpc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      upc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      uv    = ($urandom_range(0, 9) < 8);
      cls   = cls_tab[$urandom_range(0, 9)];
      ut    = (cls == 4'd11) ? 1'b1 : 1'($urandom_range(0, 1));
      utgt  = 32'h1000 + ($urandom_range(0, 3) << 4);
      if ($urandom_range(0, 9) < 7) model_predict(upc, upt, uptgt);
      else begin
        upt   = 1'($urandom_range(0, 1));
        uptgt = 32'h1000 + ($urandom_range(0, 3) << 4);
      end
      drive(fpc, uv, cls, upc, ut, utgt, upt, uptgt);
    end

    // Saturation and asynchronous mid-run reset
    drive(32'h0, 1, 4'd8, 32'h1000, 1, 32'h2000, 0, 32'h1004);
    idle(32'h1000);
    settle();
    chk("pre_reset_trained", {31'b0, bp_bus.f_pred_taken}, 32'd1);
    force dut.stat_mis_q = 32'hFFFF_FFFF;
    force dut.stat_br_q  = 32'hFFFF_FFFF;
    bp_bus.u_valid = 1; bp_bus.u_bj_inst = 4'd8; bp_bus.u_pc = 32'h1000;
    bp_bus.u_taken = 1; bp_bus.u_target = 32'h2000;
    bp_bus.u_pred_taken = 0; bp_bus.u_pred_target = 32'h1004;
    #1;
    chk("sat_mis_next", dut.stat_mis_d, 32'hFFFF_FFFF);
    chk("sat_br_next",  dut.stat_br_d,  32'hFFFF_FFFF);
    release dut.stat_mis_q;
    release dut.stat_br_q;
    rst_n = 1'b0;
    #1;
    chk("async_reset_stat_br",  bp_bus.stat_branches, 32'd0);
    chk("async_reset_stat_mis", bp_bus.stat_mispredicts, 32'd0);
    chk("async_reset_table",    {31'b0, bp_bus.f_pred_taken}, 32'd0);
    chk("async_reset_target",   bp_bus.f_pred_target, 32'h1004);
    chk("reset_mispredict_comb", {31'b0, bp_bus.mispredict}, 32'd1);
    model_reset();
    bp_bus.u_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;

    drive(32'h1000, 1, 4'd9, 32'h1000, 1, 32'h2000, 0, 32'h1004);
    idle(32'h1000);
    idle(32'h1000);
    settle();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
